// File: rtl/partition_splitter_if.sv
// Memory-port and control bundle for partition_splitter: one read port, one write port,
// plus the run/split_done job handshake.
interface partition_splitter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                         run;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0]        read_address_out;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0]        write_address_out;
  logic                         we_out;
  logic                         split_done;

  modport master (
    input  run, data_in,
    output read_address_out, data_out, write_address_out, we_out, split_done
  );

  modport slave (
    output run, data_in,
    input  read_address_out, data_out, write_address_out, we_out, split_done
  );
endinterface

// File: rtl/partition_splitter.sv
// Splits a row-major feature map into overlapping left/right column partitions.
// Optional macro SPLITTER_RELU_EN clamps negative pixels to zero on output.
module partition_splitter #(
  parameter int MAP_WIDTH       = 8,
  parameter int MAP_HEIGHT      = 8,
  parameter int PARTITION_WIDTH = 5,
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 12,
  parameter int ADDRESS_IN      = 0,
  parameter int ADDRESS_0_OUT   = 1024,
  parameter int ADDRESS_1_OUT   = 2048
) (
  input logic clk,
  input logic reset,
  partition_splitter_if.master bus
);

  // Counters are one bit wider than strictly needed so the limits themselves are representable.
  localparam int COL_W = $clog2(MAP_WIDTH + 1);
  localparam int ROW_W = $clog2(MAP_HEIGHT + 1);

  localparam logic [COL_W-1:0]      P0_LIMIT = COL_W'(PARTITION_WIDTH);
  localparam logic [COL_W-1:0]      P1_START = COL_W'(MAP_WIDTH - PARTITION_WIDTH);
  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(MAP_WIDTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(MAP_HEIGHT - 1);
  localparam logic [COL_W-1:0]      COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]      ROW_ONE  = ROW_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE_IN  = ADDR_WIDTH'(ADDRESS_IN);
  localparam logic [ADDR_WIDTH-1:0] BASE_0   = ADDR_WIDTH'(ADDRESS_0_OUT);
  localparam logic [ADDR_WIDTH-1:0] BASE_1   = ADDR_WIDTH'(ADDRESS_1_OUT);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_DATA,
    LOAD,
    WRITE_0,
    WRITE_1,
    ADVANCE,
    FINISHED
  } state_t;

  state_t state;
  state_t state_next;

  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  logic [ADDR_WIDTH-1:0]        src_addr;
  logic [ADDR_WIDTH-1:0]        addr0;
  logic [ADDR_WIDTH-1:0]        addr1;
  logic signed [DATA_WIDTH-1:0] pixel;

  logic                         in_p0;
  logic                         in_p1;
  logic                         last_pixel;
  logic [ADDR_WIDTH-1:0]        read_address;
  logic [ADDR_WIDTH-1:0]        write_address;
  logic                         we;
  logic                         done;

  assign in_p0      = (col < P0_LIMIT);
  assign in_p1      = (col >= P1_START);
  assign last_pixel = (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      src_addr <= BASE_IN;
      addr0    <= BASE_0;
      addr1    <= BASE_1;
      pixel    <= '0;
    end else begin
      case (state)
        LOAD:    pixel <= bus.data_in;
        WRITE_0: addr0 <= addr0 + ADDR_ONE;
        WRITE_1: addr1 <= addr1 + ADDR_ONE;
        ADVANCE: begin
          src_addr <= src_addr + ADDR_ONE;
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + ROW_ONE;
          end else begin
            col <= col + COL_ONE;
          end
        end
        FINISHED: begin
          col      <= '0;
          row      <= '0;
          src_addr <= BASE_IN;
          addr0    <= BASE_0;
          addr1    <= BASE_1;
        end
        default: ;
      endcase
    end
  end

  // Columns outside the left partition are always inside the right one, so LOAD can skip WRITE_0.
  always_comb begin
    state_next    = state;
    read_address  = '0;
    write_address = '0;
    we            = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run) state_next = REQUEST;
      end
      REQUEST: begin
        read_address = src_addr;
        state_next   = WAIT_DATA;
      end
      WAIT_DATA: begin
        read_address = src_addr;
        state_next   = LOAD;
      end
      LOAD: begin
        state_next = in_p0 ? WRITE_0 : WRITE_1;
      end
      WRITE_0: begin
        we            = 1'b1;
        write_address = addr0;
        state_next    = in_p1 ? WRITE_1 : ADVANCE;
      end
      WRITE_1: begin
        we            = 1'b1;
        write_address = addr1;
        state_next    = ADVANCE;
      end
      ADVANCE: begin
        state_next = last_pixel ? FINISHED : REQUEST;
      end
      FINISHED: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.read_address_out  = read_address;
  assign bus.write_address_out = write_address;
  assign bus.we_out            = we;
  assign bus.split_done        = done;

`ifdef SPLITTER_RELU_EN
  assign bus.data_out = pixel[DATA_WIDTH-1] ? '0 : pixel;
`else
  assign bus.data_out = pixel;
`endif

endmodule

// File: tb/tb_partition_splitter.sv
// Scoreboard bench for partition_splitter: one overlapping (4x2, P=3) and one
// non-overlapping (4x2, P=2) instance fed from a shared randomized source map.
module tb_partition_splitter;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int P1 = 3;
  localparam int P2 = 2;
  localparam int A0 = 64;
  localparam int A1 = 128;

  typedef struct {
    logic                is_done;
    logic [11:0]         addr;
    logic signed [15:0]  data;
    int                  gap;
  } ev_t;

  logic clk;
  logic reset;

  logic signed [15:0] src [8];
  logic signed [15:0] q1a;
  logic signed [15:0] q1b;

  ev_t exp1_q[$];
  ev_t exp2_q[$];

  int checks    = 0;
  int errors    = 0;
  int pcount    = 0;
  int mark1     = 0;
  int mark2     = 0;
  int done1_cnt = 0;
  int done2_cnt = 0;
  logic prev_we2;

  partition_splitter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus1 ();
  partition_splitter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus2 ();

  partition_splitter #(
    .MAP_WIDTH(W), .MAP_HEIGHT(H), .PARTITION_WIDTH(P1), .DATA_WIDTH(16),
    .ADDR_WIDTH(12), .ADDRESS_IN(0), .ADDRESS_0_OUT(A0), .ADDRESS_1_OUT(A1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  partition_splitter #(
    .MAP_WIDTH(W), .MAP_HEIGHT(H), .PARTITION_WIDTH(P2), .DATA_WIDTH(16),
    .ADDR_WIDTH(12), .ADDRESS_IN(0), .ADDRESS_0_OUT(A0), .ADDRESS_1_OUT(A1)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pcount <= pcount + 1;

  function automatic logic signed [15:0] fetch(input logic [11:0] a);
    logic signed [15:0] v;
    if (a < 12'd8) v = src[a[2:0]];
    else v = 16'sd0;
    return v;
  endfunction

  // Two-stage read pipeline: data appears two cycles after its address.
  always @(posedge clk) begin
    q1a          <= fetch(bus1.read_address_out);
    bus1.data_in <= q1a;
    q1b          <= fetch(bus2.read_address_out);
    bus2.data_in <= q1b;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: every source pixel lands at its row/column slot in each partition containing it.
  task automatic push_job(input int which);
    int p;
    int total;
    int nw;
    logic signed [15:0] v;
    ev_t e;
    p = (which == 1) ? P1 : P2;
    total = 1;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        v = src[r*W + c];
`ifdef SPLITTER_RELU_EN
        if (v < 0) v = 16'sd0;
`endif
        nw = 0;
        if (c < p) begin
          e.is_done = 1'b0; e.addr = 12'(A0 + r*p + c); e.data = v; e.gap = 0;
          if (which == 1) exp1_q.push_back(e); else exp2_q.push_back(e);
          nw++;
        end
        if (c >= W - p) begin
          e.is_done = 1'b0; e.addr = 12'(A1 + r*p + (c - (W - p))); e.data = v; e.gap = 0;
          if (which == 1) exp1_q.push_back(e); else exp2_q.push_back(e);
          nw++;
        end
        total += 4 + nw;
      end
    end
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.gap = total;
    if (which == 1) exp1_q.push_back(e); else exp2_q.push_back(e);
  endtask

  always @(negedge clk) begin : mon1
    ev_t e;
    if (!reset) begin
      if (bus1.we_out) begin
        if (exp1_q.size() == 0) begin
          check_output("d1 unexpected write addr", int'(bus1.write_address_out), -1);
        end else begin
          e = exp1_q.pop_front();
          check_output("d1 event is write", 0, int'(e.is_done));
          check_output("d1 write addr", int'(bus1.write_address_out), int'(e.addr));
          check_output("d1 write data", int'(bus1.data_out), int'(e.data));
        end
      end else begin
        check_output("d1 idle write addr", int'(bus1.write_address_out), 0);
      end
      if (bus1.split_done) begin
        done1_cnt++;
        if (exp1_q.size() == 0) begin
          check_output("d1 unexpected split_done", 1, 0);
        end else begin
          e = exp1_q.pop_front();
          check_output("d1 event is done", 1, int'(e.is_done));
          check_output("d1 done cycle", pcount - mark1, e.gap);
        end
        mark1 = pcount + 1;
      end
    end
  end

  always @(negedge clk) begin : mon2
    ev_t e;
    if (!reset) begin
      if (bus2.we_out) begin
        check_output("d2 consecutive writes", int'(prev_we2), 0);
        if (exp2_q.size() == 0) begin
          check_output("d2 unexpected write addr", int'(bus2.write_address_out), -1);
        end else begin
          e = exp2_q.pop_front();
          check_output("d2 event is write", 0, int'(e.is_done));
          check_output("d2 write addr", int'(bus2.write_address_out), int'(e.addr));
          check_output("d2 write data", int'(bus2.data_out), int'(e.data));
        end
      end
      if (bus2.split_done) begin
        done2_cnt++;
        if (exp2_q.size() == 0) begin
          check_output("d2 unexpected split_done", 1, 0);
        end else begin
          e = exp2_q.pop_front();
          check_output("d2 event is done", 1, int'(e.is_done));
          check_output("d2 done cycle", pcount - mark2, e.gap);
        end
        mark2 = pcount + 1;
      end
    end
    prev_we2 = bus2.we_out;
  end

  task automatic wait_done(input int which, input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if ((which == 1 && done1_cnt >= target) || (which == 2 && done2_cnt >= target)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_output((which == 1) ? "d1 done timeout" : "d2 done timeout", 0, 1);
  endtask

  task automatic apply_stimulus(input bit use1, input bit use2);
    int t1;
    int t2;
    t1 = done1_cnt + 1;
    t2 = done2_cnt + 1;
    if (use1) push_job(1);
    if (use2) push_job(2);
    @(negedge clk);
    if (use1) begin bus1.run = 1'b1; mark1 = pcount; end
    if (use2) begin bus2.run = 1'b1; mark2 = pcount; end
    @(negedge clk);
    bus1.run = 1'b0;
    bus2.run = 1'b0;
    if (use1) wait_done(1, t1);
    if (use2) wait_done(2, t2);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int target;
    bit hit;
    reset     = 1'b1;
    bus1.run  = 1'b0;
    bus2.run  = 1'b0;
    prev_we2  = 1'b0;
    for (int i = 0; i < 8; i++) src[i] = 16'(i + 1);

    repeat (3) @(negedge clk);
    check_output("d1 reset we_out", int'(bus1.we_out), 0);
    check_output("d1 reset split_done", int'(bus1.split_done), 0);
    check_output("d1 reset read addr", int'(bus1.read_address_out), 0);
    check_output("d1 reset data_out", int'(bus1.data_out), 0);
    check_output("d2 reset we_out", int'(bus2.we_out), 0);
    check_output("d2 reset split_done", int'(bus2.split_done), 0);
    check_output("d2 reset write addr", int'(bus2.write_address_out), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] layout and timing, overlap and no-overlap");
    apply_stimulus(1, 1);

    $display("[TB] negative pixels");
    for (int i = 0; i < 8; i++) src[i] = 16'($urandom);
    src[0] = -16'sd5;
    src[1] = 16'sd7;
    apply_stimulus(1, 0);

    $display("[TB] randomized maps");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) src[i] = 16'($urandom);
      apply_stimulus(1, 1);
    end

    $display("[TB] back-to-back jobs with run held high");
    for (int i = 0; i < 8; i++) src[i] = 16'($urandom);
    target = done1_cnt;
    push_job(1);
    push_job(1);
    @(negedge clk);
    bus1.run = 1'b1;
    mark1 = pcount;
    wait_done(1, target + 1);
    repeat (3) @(negedge clk);
    bus1.run = 1'b0;
    wait_done(1, target + 2);
    repeat (3) @(negedge clk);

    $display("[TB] reset during third pixel's left write");
    for (int i = 0; i < 8; i++) src[i] = 16'($urandom);
    target = done1_cnt;
    push_job(1);
    @(negedge clk);
    bus1.run = 1'b1;
    mark1 = pcount;
    @(negedge clk);
    bus1.run = 1'b0;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (bus1.we_out && bus1.write_address_out == 12'(A0 + 2)) begin
        hit = 1;
        break;
      end
    end
    check_output("third pixel left write reached", int'(hit), 1);
    reset = 1'b1;
    #1;
    check_output("we_out drops on reset", int'(bus1.we_out), 0);
    exp1_q.delete();
    exp2_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check_output("no split_done after abort", done1_cnt, target);
    apply_stimulus(1, 0);

    check_output("d1 scoreboard drained", exp1_q.size(), 0);
    check_output("d2 scoreboard drained", exp2_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
